// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO: frames words as start + data (LSB first)
// + optional parity + stop bit(s), back-to-back while the FIFO holds words.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 25,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_BITS-1:0]        in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        out_tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
   localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
   localparam logic          STOP_LAST = (STOP_BITS == 2);

   if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("uart_tx_fifo: illegal parameter value");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   state_t               state, state_nxt;
   logic [BW-1:0]        baud, baud_nxt;
   logic [IW-1:0]        idx, idx_nxt;
   logic                 stop_cnt, stop_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic                 par_bit, par_nxt;
   logic                 tx_nxt;
   logic                 baud_last;
   logic                 push, pop;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        rd_ptr, wr_ptr;
   logic [DATA_BITS-1:0] head;

   assign in_ready  = (level != LVL_FULL);
   assign push      = in_valid && in_ready;
   assign head      = mem[rd_ptr];
   assign baud_last = (baud == BAUD_LAST);
   assign busy      = (state != S_IDLE) || (level != '0);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         baud     <= '0;
         idx      <= '0;
         stop_cnt <= 1'b0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         out_tx   <= 1'b1;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
      end else begin
         state    <= state_nxt;
         baud     <= baud_nxt;
         idx      <= idx_nxt;
         stop_cnt <= stop_nxt;
         shreg    <= shreg_nxt;
         par_bit  <= par_nxt;
         out_tx   <= tx_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      baud_nxt  = baud;
      idx_nxt   = idx;
      stop_nxt  = stop_cnt;
      shreg_nxt = shreg;
      par_nxt   = par_bit;
      pop       = 1'b0;
      tx_nxt    = 1'b1;
      if (state != S_IDLE) baud_nxt = baud_last ? '0 : baud + 1'b1;
      case (state)
         S_IDLE: if (level != '0) begin
            pop       = 1'b1;
            state_nxt = S_START;
         end
         S_START: if (baud_last) state_nxt = S_DATA;
         S_DATA: if (baud_last) begin
            shreg_nxt = shreg >> 1;
            if (idx == IDX_LAST) begin
               idx_nxt   = '0;
               state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
         S_PAR: if (baud_last) state_nxt = S_STOP;
         S_STOP: if (baud_last) begin
            if (stop_cnt == STOP_LAST) begin
               stop_nxt = 1'b0;
               // Reload on the final stop cycle so the next start bit has no gap.
               if (level != '0) begin
                  pop       = 1'b1;
                  state_nxt = S_START;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else begin
               stop_nxt = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (pop) begin
         shreg_nxt = head;
         par_nxt   = (^head) ^ (PARITY == 2);
         idx_nxt   = '0;
         baud_nxt  = '0;
      end
      // out_tx is registered from the state being entered, so it lines up with it.
      case (state_nxt)
         S_START: tx_nxt = 1'b0;
         S_DATA:  tx_nxt = shreg_nxt[0];
         S_PAR:   tx_nxt = par_nxt;
         default: tx_nxt = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parameterisations share one clock; a per-cycle
// line monitor compares every frame against a scoreboard of expected frames.
module tb_uart_tx_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1;

   logic [8:0] din [4];
   logic       vld [4];
   logic       rdy [4];
   logic       tx  [4];
   logic       bsy [4];
   logic [2:0] lvl [4];

   localparam int CPB_T [4] = '{25, 25, 25, 4};
   localparam int DB_T  [4] = '{8, 8, 8, 7};
   localparam int PAR_T [4] = '{0, 1, 2, 0};
   localparam int NB_T  [4] = '{10, 12, 11, 9};

   uart_tx_fifo u0 (.clk(clk), .rst(rst), .in_data(din[0][7:0]), .in_valid(vld[0]),
                    .in_ready(rdy[0]), .out_tx(tx[0]), .busy(bsy[0]), .level(lvl[0]));
   uart_tx_fifo #(.PARITY(1), .STOP_BITS(2)) u1 (.clk(clk), .rst(rst), .in_data(din[1][7:0]),
                    .in_valid(vld[1]), .in_ready(rdy[1]), .out_tx(tx[1]), .busy(bsy[1]), .level(lvl[1]));
   uart_tx_fifo #(.PARITY(2)) u2 (.clk(clk), .rst(rst), .in_data(din[2][7:0]), .in_valid(vld[2]),
                    .in_ready(rdy[2]), .out_tx(tx[2]), .busy(bsy[2]), .level(lvl[2]));
   uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7)) u3 (.clk(clk), .rst(rst), .in_data(din[3][6:0]),
                    .in_valid(vld[3]), .in_ready(rdy[3]), .out_tx(tx[3]), .busy(bsy[3]), .level(lvl[3]));

   typedef struct {
      int         inst;
      logic [8:0] data;
      logic [15:0] frame;   // line bits, bit 0 first on the wire
   } vec_t;
   vec_t vt [8];

   int          checks = 0, errors = 0, cyc = 0;
   logic [15:0] sbq [4][$];
   logic [15:0] exp_next [4], cur [4];
   bit          active [4], bad [4], bogus [4];
   int          pos [4], starts [4], lvl_m [4], push_cyc [4];
   bit          lat_chk = 0, gap_chk = 0, have_prev = 0, saw_full = 0;
   int          prev_start = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] frame_of(int k, logic [8:0] d);
      logic [15:0] f = '1;
      int p = 1;
      logic x = 1'b0;
      f[0] = 1'b0;
      for (int i = 0; i < DB_T[k]; i++) begin
         f[p] = d[i];
         x ^= d[i];
         p++;
      end
      if (PAR_T[k] != 0) f[p] = (PAR_T[k] == 2) ? ~x : x;
      return f;
   endfunction

   // One clock: capture handshakes before the edge, then observe outputs 1ns after.
   task automatic tick();
      bit   hs [4];
      logic r;
      bit   on;
      int   b;
      logic e;
      r = rst;
      for (int k = 0; k < 4; k++) hs[k] = vld[k] && rdy[k];
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 4; k++) begin
         on = 0;
         if (r) begin
            sbq[k].delete();
            active[k] = 0;
            lvl_m[k]  = 0;
         end else begin
            if (hs[k]) begin
               sbq[k].push_back(exp_next[k]);
               lvl_m[k]++;
               push_cyc[k] = cyc;
            end
            if (!active[k] && tx[k] === 1'b0) begin
               starts[k]++;
               active[k] = 1;
               pos[k]    = 0;
               bad[k]    = 0;
               if (sbq[k].size() == 0) begin
                  bogus[k] = 1;
                  chk($sformatf("unexpected_frame i%0d", k), 1, 0);
               end else begin
                  bogus[k] = 0;
                  cur[k]   = sbq[k].pop_front();
                  lvl_m[k]--;
               end
               if (k == 0 && lat_chk) begin
                  chk("first_start_latency", cyc - push_cyc[0], 1);
                  lat_chk = 0;
               end
               if (k == 0 && gap_chk) begin
                  if (have_prev) chk("frame_spacing", cyc - prev_start, 250);
                  prev_start = cyc;
                  have_prev  = 1;
               end
            end
            if (active[k]) begin
               on = 1;
               b  = pos[k] / CPB_T[k];
               e  = cur[k][b];
               if (!bogus[k] && tx[k] !== e) bad[k] = 1;
               pos[k]++;
               if (pos[k] % CPB_T[k] == 0) begin
                  if (!bogus[k]) chk($sformatf("frame_bit i%0d b%0d", k, b), bad[k] ? ~e : e, e);
                  bad[k] = 0;
               end
               if (pos[k] == NB_T[k] * CPB_T[k]) active[k] = 0;
            end
         end
         chk($sformatf("level i%0d", k), lvl[k], lvl_m[k]);
         chk($sformatf("in_ready i%0d", k), rdy[k], lvl_m[k] != 4);
         chk($sformatf("busy i%0d", k), bsy[k], on || lvl_m[k] != 0);
      end
      if (lvl[0] == 3'd4) saw_full = 1;
   endtask

   task automatic send(int k, logic [8:0] d, logic [15:0] f);
      bit hs = 0;
      int n = 0;
      din[k] = d;
      vld[k] = 1'b1;
      exp_next[k] = f;
      do begin
         hs = rdy[k];
         tick();
         n++;
      end while (!hs && n < 1000);
      vld[k] = 1'b0;
      if (!hs) chk($sformatf("send_timeout i%0d", k), 0, 1);
   endtask

   task automatic wait_idle(int k, int bound);
      int n = 0;
      while ((bsy[k] || active[k] || sbq[k].size() != 0) && n < bound) begin
         tick();
         n++;
      end
      chk($sformatf("idle_timeout i%0d", k), n < bound, 1);
      chk($sformatf("idle_tx i%0d", k), tx[k], 1);
      chk($sformatf("idle_busy i%0d", k), bsy[k], 0);
   endtask

   initial begin
      int s, n;
      bit hs;
      for (int k = 0; k < 4; k++) begin
         vld[k] = 1'b0;
         din[k] = '0;
         exp_next[k] = '0;
      end
      vt[0] = '{0, 9'h0A5, {6'b0, 1'b1, 8'hA5, 1'b0}};
      vt[1] = '{0, 9'h03C, {6'b0, 1'b1, 8'h3C, 1'b0}};
      vt[2] = '{1, 9'h007, {4'b0, 2'b11, 1'b1, 8'h07, 1'b0}};
      vt[3] = '{2, 9'h007, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}};
      vt[4] = '{3, 9'h055, {7'b0, 1'b1, 7'h55, 1'b0}};
      vt[5] = '{1, 9'h000, {4'b0, 2'b11, 1'b0, 8'h00, 1'b0}};
      vt[6] = '{2, 9'h000, {5'b0, 1'b1, 1'b1, 8'h00, 1'b0}};
      vt[7] = '{3, 9'h02A, {7'b0, 1'b1, 7'h2A, 1'b0}};

      rst = 1'b1;
      tick();
      tick();
      chk("reset_tx", tx[0], 1);
      chk("reset_ready", rdy[0], 1);
      chk("reset_busy", bsy[0], 0);
      chk("reset_level", lvl[0], 0);
      rst = 1'b0;
      tick();

      // Single frames, expected line patterns written out per vector.
      for (int i = 0; i < 8; i++) begin
         if (i == 0) lat_chk = 1;
         send(vt[i].inst, vt[i].data, vt[i].frame);
         wait_idle(vt[i].inst, 2000);
         if (i == 0) chk("latency_seen", lat_chk, 0);
      end

      // Six words pushed back to back; FIFO fills and frames run gap-free.
      gap_chk = 1;
      have_prev = 0;
      saw_full = 0;
      s = starts[0];
      for (int w = 1; w <= 6; w++) send(0, 9'(w), frame_of(0, 9'(w)));
      wait_idle(0, 3000);
      gap_chk = 0;
      chk("fifo_full_seen", saw_full, 1);
      chk("b2b_frame_count", starts[0] - s, 6);

      // Full FIFO: a push offered on the pop cycle is refused.
      for (int w = 0; w < 5; w++) send(0, 9'(8'h30 + w), frame_of(0, 9'(8'h30 + w)));
      chk("full_level", lvl[0], 4);
      din[0] = 9'h0C3;
      vld[0] = 1'b1;
      exp_next[0] = frame_of(0, 9'h0C3);
      s = starts[0];
      n = 0;
      hs = 0;
      do begin
         hs = rdy[0];
         tick();
         n++;
      end while (starts[0] == s && n < 400);
      vld[0] = 1'b0;
      chk("pop_seen", starts[0] != s, 1);
      chk("full_push_refused", hs, 0);
      chk("level_after_pop", lvl[0], 3);
      wait_idle(0, 2000);

      // Reset in the middle of data bit 3 with two words still queued.
      send(0, 9'h0F0, frame_of(0, 9'h0F0));
      send(0, 9'h00F, frame_of(0, 9'h00F));
      send(0, 9'h0AA, frame_of(0, 9'h0AA));
      n = 0;
      while (!(active[0] && pos[0] == 112) && n < 1000) begin
         tick();
         n++;
      end
      chk("reach_data_bit3", n < 1000, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midframe_rst_tx", tx[0], 1);
      chk("midframe_rst_level", lvl[0], 0);
      chk("midframe_rst_ready", rdy[0], 1);
      chk("midframe_rst_busy", bsy[0], 0);
      s = starts[0];
      repeat (600) tick();
      chk("no_frames_after_rst", starts[0] - s, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
